hdc_bundler: RTL and testbench

- Stage directly downstream of the P/L XOR binding stage.
- Consumes one bound hypervector per accepted beat and keeps one saturating popcount per dimension over a frame of NUM_FEAT beats.
- At frame end it thresholds every counter into a single bundled (majority) hypervector and presents it under a valid/ready handshake to the class-memory or similarity stage.

---
 rtl/hdc_pkg.sv | 22 ++
 rtl/hdc_bit_counter.sv | 42 ++++
 rtl/hdc_bundler.sv | 107 ++++++++++
 tb/tb_hdc_bundler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared sizes, hypervector type and bundler FSM encoding.
// Rev 1.0
`default_nettype none

package hdc_pkg;

  localparam int HDC_D        = 1024;
  localparam int HDC_NUM_FEAT = 143;
  localparam int HDC_CNT_W    = 8;
  localparam int HDC_THRESH   = 72;

  typedef logic [HDC_D-1:0] hv_t;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    THRESH = 2'd1,
    HOLD   = 2'd2
  } bundler_state_e;

endpackage

`default_nettype wire

// File: rtl/hdc_bit_counter.sv
// hdc_bit_counter: per-dimension saturating popcount with registered threshold bit.
// Rev 1.0
`default_nettype none

module hdc_bit_counter
  import hdc_pkg::*;
#(
  parameter int CNT_W  = HDC_CNT_W,
  parameter int THRESH = HDC_THRESH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic sample,
  output logic ge
);

  localparam logic [31:0] THR_U = 32'(THRESH);

  logic [CNT_W-1:0] cnt;

  // ge survives clr so the last bundle stays visible after a frame abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ge  <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (sample) begin
        ge <= (32'(cnt) >= THR_U);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hdc_bundler.sv
// hdc_bundler: accumulates NUM_FEAT bound hypervectors and emits their majority bundle.
// Rev 1.0
`default_nettype none

module hdc_bundler
  import hdc_pkg::*;
#(
  parameter int D        = HDC_D,
  parameter int NUM_FEAT = HDC_NUM_FEAT,
  parameter int CNT_W    = HDC_CNT_W,
  parameter int THRESH   = HDC_THRESH,
  localparam int FC_W    = $clog2(NUM_FEAT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [D-1:0]    in_hv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [D-1:0]    bundled_hv,
  output logic [FC_W-1:0] feat_cnt
);

  localparam logic [1:0] S_ACCUM  = hdc_pkg::ACCUM;
  localparam logic [1:0] S_THRESH = hdc_pkg::THRESH;
  localparam logic [1:0] S_HOLD   = hdc_pkg::HOLD;

  if (NUM_FEAT > (2 ** CNT_W) - 1) begin : g_cnt_w_check
    $error("hdc_bundler: CNT_W too narrow to count NUM_FEAT beats");
  end

  logic [1:0] state;
  logic       started;
  logic       beat;
  logic       last_beat;
  logic       cnt_clr;
  logic       sample;

  // started keeps in_ready low while rst_n is asserted
  assign in_ready  = started && (state == S_ACCUM);
  assign beat      = in_valid && in_ready && !clear;
  assign last_beat = (feat_cnt == FC_W'(NUM_FEAT - 1));
  assign cnt_clr   = clear || ((state == S_HOLD) && out_ready);
  assign sample    = (state == S_THRESH) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACCUM;
      started   <= 1'b0;
      feat_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      started <= 1'b1;
      if (clear) begin
        state     <= S_ACCUM;
        feat_cnt  <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_ACCUM: begin
            if (beat) begin
              feat_cnt <= feat_cnt + FC_W'(1);
              if (last_beat) begin
                state <= S_THRESH;
              end
            end
          end
          S_THRESH: begin
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
          S_HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              feat_cnt  <= '0;
              state     <= S_ACCUM;
            end
          end
          default: begin
            state     <= S_ACCUM;
            feat_cnt  <= '0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < D; i++) begin : g_bit
    hdc_bit_counter #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .inc    (beat && in_hv[i]),
      .sample (sample),
      .ge     (bundled_hv[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_hdc_bundler.sv
// tb_hdc_bundler: directed + randomized checks of hdc_bundler against a popcount model.
// Rev 1.0
`default_nettype none

module tb_hdc_bundler;

  logic       clk;
  logic       rst_n;

  logic       clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_hv, bundled_hv;
  logic [2:0] feat_cnt;

  logic          d_clear, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [1023:0] d_in_hv, d_bundled_hv;
  logic [7:0]    d_feat_cnt;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] acc_q[$];
  logic [7:0] last_bundle;
  logic [63:0] rnd;

  hdc_bundler #(.D(8), .NUM_FEAT(5), .CNT_W(3), .THRESH(3)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_hv(in_hv),
    .out_valid(out_valid), .out_ready(out_ready),
    .bundled_hv(bundled_hv), .feat_cnt(feat_cnt)
  );

  hdc_bundler dut_def (
    .clk(clk), .rst_n(rst_n), .clear(d_clear),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_hv(d_in_hv),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .bundled_hv(d_bundled_hv), .feat_cnt(d_feat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Majority of every dimension over the beats accepted so far.
  function automatic logic [7:0] model_bundle();
    logic [7:0] r;
    int c;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      foreach (acc_q[k]) c += int'(acc_q[k][b]);
      r[b] = (c >= 3);
    end
    return r;
  endfunction

  task automatic send_beat(input logic [7:0] v, input bit gaps);
    int tries;
    bit done;
    bit acc;
    tries = 0;
    done  = 0;
    while (!done) begin
      if (gaps && tries < 3 && $urandom_range(1) == 0) begin
        in_valid = 1'b0;
        in_hv    = 'x;
      end else begin
        in_valid = 1'b1;
        in_hv    = v;
      end
      acc = in_valid && in_ready;
      step();
      tries++;
      if (acc) begin
        acc_q.push_back(v);
        done = 1;
      end
      check("feat_cnt_step", feat_cnt, acc_q.size());
      if (!done && tries > 20) begin
        check("in_ready_stuck", in_ready, 1);
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_hv    = 'x;
  endtask

  task automatic run_frame(input logic [39:0] f, input bit gaps, input string tag);
    acc_q.delete();
    for (int k = 0; k < 5; k++) send_beat(f[8*k +: 8], gaps);
    check({tag, "_thr_in_ready"}, in_ready, 0);
    check({tag, "_thr_out_valid"}, out_valid, 0);
    step();
    last_bundle = model_bundle();
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_hold_in_ready"}, in_ready, 0);
    check({tag, "_bundle"}, bundled_hv, last_bundle);
  endtask

  task automatic release_frame(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, out_valid, 0);
    check({tag, "_rel_in_ready"}, in_ready, 1);
    check({tag, "_rel_feat_cnt"}, feat_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; in_valid = 1'b0; in_hv = '0; out_ready = 1'b0;
    d_clear = 1'b0; d_in_valid = 1'b0; d_in_hv = '0; d_out_ready = 1'b0;
    last_bundle = '0;

    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bundle", bundled_hv, 0);
    check("rst_feat_cnt", feat_cnt, 0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // 0F x3 then F0 x2: low nibble majority
    run_frame(40'hF0F00F0F0F, 1'b0, "fa");
    check("fa_const", bundled_hv, 8'h0F);
    release_frame("fa");

    // 0F x2 then F0 x3: upper nibble reaches the threshold exactly
    run_frame(40'hF0F0F00F0F, 1'b0, "fb");
    check("fb_tie_const", bundled_hv, 8'hF0);
    release_frame("fb");

    run_frame(40'hF0F00F0F0F, 1'b1, "fa_gap");
    check("fa_gap_const", bundled_hv, 8'h0F);
    release_frame("fa_gap");

    rnd = {$urandom, $urandom};
    run_frame(rnd[39:0], 1'b0, "hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_hv    = 8'($urandom);
      step();
      check("hold_out_valid", out_valid, 1);
      check("hold_bundle", bundled_hv, last_bundle);
      check("hold_in_ready", in_ready, 0);
      check("hold_feat_cnt", feat_cnt, 5);
    end
    in_valid = 1'b0;
    release_frame("hold");
    rnd = {$urandom, $urandom};
    run_frame(rnd[39:0], 1'b0, "after_hold");
    release_frame("after_hold");

    for (int f = 0; f < 8; f++) begin
      rnd = {$urandom, $urandom};
      run_frame(rnd[39:0], 1'b1, "rand");
      repeat ($urandom_range(3)) step();
      release_frame("rand");
    end

    acc_q.delete();
    for (int k = 0; k < 3; k++) send_beat(8'($urandom), 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_hv    = 8'hFF;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_feat_cnt", feat_cnt, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_bundle_kept", bundled_hv, last_bundle);
    run_frame({5{8'hFF}}, 1'b0, "after_clr");
    check("after_clr_const", bundled_hv, 8'hFF);
    release_frame("after_clr");

    rnd = {$urandom, $urandom};
    run_frame(rnd[39:0], 1'b0, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_bundle", bundled_hv, 0);
    check("arst_feat_cnt", feat_cnt, 0);
    check("arst_in_ready", in_ready, 0);
    #2 rst_n = 1'b1;
    step();
    check("arst_rel_in_ready", in_ready, 1);
    check("arst_rel_out_valid", out_valid, 0);

    // Default-sized block: 143 all-ones beats with the consumer always ready
    d_out_ready = 1'b1;
    for (int k = 0; k < 143; k++) begin
      d_in_valid = 1'b1;
      d_in_hv    = '1;
      step();
    end
    d_in_valid = 1'b0;
    d_in_hv    = '0;
    check("def_feat_cnt", d_feat_cnt, 143);
    check("def_thr_in_ready", d_in_ready, 0);
    check("def_thr_out_valid", d_out_valid, 0);
    step();
    check("def_out_valid", d_out_valid, 1);
    check("def_hold_in_ready", d_in_ready, 0);
    check("def_bundle", d_bundled_hv, {1024{1'b1}});
    step();
    check("def_rel_out_valid", d_out_valid, 0);
    check("def_rel_in_ready", d_in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
